// File: rtl/icache_miss_arbiter.sv
// Instruction-side miss arbiter: issues demand/prefetch block loads to memory,
// tracks them by bus tag in a small MSHR table and fills returning blocks.
module icache_miss_arbiter #(
   parameter int NUM_MSHR = 4,
   parameter int BLOCK_W  = 64
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               if_miss_valid,
   input  logic [31:0]        if_miss_addr,
   input  logic               pf_request_valid,
   input  logic [31:0]        pf_requested_addr,
   input  logic               mem_busy,
   input  logic [3:0]         mem2proc_response,
   input  logic [3:0]         mem2proc_tag,
   input  logic [BLOCK_W-1:0] mem2proc_data,
   output logic [1:0]         proc2mem_command,
   output logic [31:0]        proc2mem_addr,
   output logic               icache_pf_stall,
   output logic               demand_pending,
   output logic               wr_en,
   output logic [31:0]        wr_addr,
   output logic [BLOCK_W-1:0] wr_data
);

   localparam logic [1:0] BUS_NONE = 2'd0;
   localparam logic [1:0] BUS_LOAD = 2'd1;
   localparam int IDX_W = (NUM_MSHR > 1) ? $clog2(NUM_MSHR) : 1;

   logic [NUM_MSHR-1:0] valid_q, valid_d;
   logic [28:0]         block_q [NUM_MSHR];
   logic [28:0]         block_d [NUM_MSHR];
   logic [3:0]          tag_q   [NUM_MSHR];
   logic [3:0]          tag_d   [NUM_MSHR];

   logic [28:0]         dm_blk, pf_blk, alloc_blk;
   logic                fill_hit, free_found, dm_match, pf_match;
   logic                dm_issue, alloc;
   logic [IDX_W-1:0]    fill_idx, free_idx;

   // Block offset bits never reach the bus or the fill path.
   logic unused_offset_bits;
   assign unused_offset_bits = ^{if_miss_addr[2:0], pf_requested_addr[2:0]};

   assign dm_blk = if_miss_addr[31:3];
   assign pf_blk = pf_requested_addr[31:3];

   // Table lookups: fill tag hit, lowest free entry, and block matches.
   // An entry being filled this cycle still counts as in flight for dedupe.
   always_comb begin
      fill_hit   = 1'b0;
      fill_idx   = '0;
      free_found = 1'b0;
      free_idx   = '0;
      dm_match   = 1'b0;
      pf_match   = 1'b0;
      for (int i = 0; i < NUM_MSHR; i++) begin
         if (!fill_hit && valid_q[i] && (mem2proc_tag != 4'd0) && (tag_q[i] == mem2proc_tag)) begin
            fill_hit = 1'b1;
            fill_idx = i[IDX_W-1:0];
         end
         if (!free_found && !valid_q[i]) begin
            free_found = 1'b1;
            free_idx   = i[IDX_W-1:0];
         end
         if (valid_q[i] && (block_q[i] == dm_blk)) dm_match = 1'b1;
         if (valid_q[i] && (block_q[i] == pf_blk)) pf_match = 1'b1;
      end
      if (reset) fill_hit = 1'b0;
   end

   always_comb begin
      proc2mem_command = BUS_NONE;
      proc2mem_addr    = 32'd0;
      icache_pf_stall  = pf_request_valid;
      demand_pending   = 1'b0;
      wr_en            = 1'b0;
      wr_addr          = 32'd0;
      wr_data          = '0;
      dm_issue         = 1'b0;
      alloc            = 1'b0;
      alloc_blk        = '0;
      if (!reset) begin
         if (fill_hit) begin
            wr_en   = 1'b1;
            wr_addr = {block_q[fill_idx], 3'b000};
            wr_data = mem2proc_data;
         end
         if (if_miss_valid) begin
            if (dm_match) begin
               demand_pending = 1'b1;
            end else if (free_found && !mem_busy) begin
               proc2mem_command = BUS_LOAD;
               proc2mem_addr    = {dm_blk, 3'b000};
               dm_issue         = 1'b1;
               if (mem2proc_response != 4'd0) begin
                  alloc     = 1'b1;
                  alloc_blk = dm_blk;
               end
            end
         end
         if (pf_request_valid) begin
            if (pf_match || (if_miss_valid && (pf_blk == dm_blk))) begin
               icache_pf_stall = 1'b0;
            end else if (!dm_issue && free_found && !mem_busy) begin
               proc2mem_command = BUS_LOAD;
               proc2mem_addr    = {pf_blk, 3'b000};
               if (mem2proc_response != 4'd0) begin
                  alloc           = 1'b1;
                  alloc_blk       = pf_blk;
                  icache_pf_stall = 1'b0;
               end
            end
         end
      end
   end

   // Fill clears a valid entry while allocation only targets an entry that
   // was free at the start of the cycle, so the two never collide.
   always_comb begin
      valid_d = valid_q;
      for (int i = 0; i < NUM_MSHR; i++) begin
         block_d[i] = block_q[i];
         tag_d[i]   = tag_q[i];
      end
      if (fill_hit) valid_d[fill_idx] = 1'b0;
      if (alloc) begin
         valid_d[free_idx] = 1'b1;
         block_d[free_idx] = alloc_blk;
         tag_d[free_idx]   = mem2proc_response;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) valid_q <= '0;
      else       valid_q <= valid_d;
      for (int i = 0; i < NUM_MSHR; i++) begin
         block_q[i] <= block_d[i];
         tag_q[i]   <= tag_d[i];
      end
   end

endmodule
